// File: rtl/cpu_sequencer_if.sv
// Loader, control and core-side signals of the instruction sequencer.
// master = host/core side, slave = sequencer.
interface cpu_sequencer_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       step_mode;
  logic       step;
  logic       zf_in;
  logic       halt_in;
  logic [7:0] opcode;
  logic       cpu_reset;
  logic [3:0] pc;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] instr_count;

  modport master (
    output prog_we, prog_addr, prog_data,
    output start, step_mode, step,
    output zf_in, halt_in,
    input  opcode, cpu_reset, pc,
    input  busy, done, timeout, instr_count
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    input  start, step_mode, step,
    input  zf_in, halt_in,
    output opcode, cpu_reset, pc,
    output busy, done, timeout, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the 4-bit core: 16x8 program store,
// local jump/branch resolution, halt/timeout/external stop.
module cpu_sequencer #(
  parameter logic [7:0] NOP_OP    = 8'h50,
  parameter logic [7:0] CLR_OP    = 8'hE0,
  parameter logic [7:0] MAX_INSTR = 8'd200
) (
  input logic             clk,
  input logic             reset,
  cpu_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [7:0] r_mem [16];
  logic [1:0] r_state;
  logic [3:0] r_pc;
  logic [7:0] r_cnt;
  logic       r_tmo;
  logic       r_cpu_reset;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_instr;
  logic       w_issue;
  logic [7:0] w_cnt_inc;
  logic [3:0] w_pc_adv;
  logic [1:0] w_state;
  logic [3:0] w_pc;
  logic [7:0] w_cnt;
  logic       w_tmo;
  logic [7:0] w_opcode;

  assign w_instr   = r_mem[r_pc];
  assign w_issue   = (r_state == S_RUN) &&
                     (!bus.step_mode || bus.step);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_comb begin
    w_pc_adv = r_pc + 4'd1;
    unique case (1'b1)
      (w_instr[7:4] == 4'h9):
        w_pc_adv = w_instr[3:0];
      (w_instr[7:4] == 4'h8) && !bus.zf_in:
        w_pc_adv = w_instr[3:0];
      default:
        w_pc_adv = r_pc + 4'd1;
    endcase
  end

  // halt_in outranks the instruction; halt opcode outranks the budget
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_cnt   = r_cnt;
    w_tmo   = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state = S_CLEAR;
      end
      S_CLEAR: begin
        w_state = S_RUN;
        w_pc    = 4'd0;
        w_cnt   = 8'd0;
        w_tmo   = 1'b0;
      end
      S_RUN: begin
        if (bus.halt_in) begin
          w_state = S_DONE;
        end else if (w_issue) begin
          w_cnt = w_cnt_inc;
          if (w_instr[7:4] == 4'hF) begin
            w_state = S_DONE;
          end else begin
            w_pc = w_pc_adv;
            if (w_cnt_inc == MAX_INSTR) begin
              w_state = S_DONE;
              w_tmo   = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (bus.start) w_state = S_CLEAR;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= 4'd0;
      r_cnt       <= 8'd0;
      r_tmo       <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_cnt       <= w_cnt;
      r_tmo       <= w_tmo;
      r_cpu_reset <= (w_state == S_CLEAR);
      r_busy      <= (w_state == S_CLEAR) ||
                     (w_state == S_RUN);
      r_done      <= (w_state == S_DONE);
    end
  end

  // store survives reset; loadable only while no run is active
  always_ff @(posedge clk) begin
    if (bus.prog_we &&
        (r_state == S_IDLE || r_state == S_DONE))
      r_mem[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    w_opcode = NOP_OP;
    case (r_state)
      S_CLEAR: w_opcode = CLR_OP;
      S_RUN:   w_opcode = w_issue ? w_instr : NOP_OP;
      default: w_opcode = NOP_OP;
    endcase
  end

  assign bus.opcode      = w_opcode;
  assign bus.cpu_reset   = r_cpu_reset;
  assign bus.pc          = r_pc;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_tmo;
  assign bus.instr_count = r_cnt;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Instruction sequencer for the 4-bit CPU core. Holds a 16 x 8-bit program store and drives the core's opcode input one instruction per clock.
- Resolves jump and branch opcodes locally using the core's ZF flag, and stops the program on halt, timeout or an external halt.
- Sits between the testbench/host loader and the CPU. It owns the core's reset and opcode inputs.

Parameters:
- NOP_OP, 8'h50: opcode issued when no program instruction is being executed (core opcode 0x5 = output A; leaves A/B unchanged).
- CLR_OP, 8'hE0: opcode issued in the CLEAR state (core opcode 0xE = clear stack pointers).
- MAX_INSTR, 8'd200: instruction budget. Reaching it ends the run with a timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- prog_we  in  1  program-store write strobe
- prog_addr  in  4  program-store write address
- prog_data  in  8  program-store write data
- start  in  1  begin a run; a one-cycle pulse is sufficient
- step_mode  in  1  1 = issue an instruction only on a step pulse
- step  in  1  single-step request; effective only while step_mode=1
- zf_in  in  1  core ZF output
- halt_in  in  1  core halt output
- opcode  out  8  opcode presented to the core
- cpu_reset  out  1  reset to the core
- pc  out  4  address of the instruction being issued / next to be issued
- busy  out  1  high in CLEAR and RUN
- done  out  1  high in DONE
- timeout  out  1  sticky; set when a run ends by exhausting MAX_INSTR
- instr_count  out  8  instructions issued in the current run, saturating at 255

Behaviour:
Reset:
- State returns to IDLE. Outputs: opcode=NOP_OP, cpu_reset=1, pc=0, busy=0, done=0, timeout=0, instr_count=0.
- Program store is not cleared; its contents survive reset.
- Reset asserted mid-run aborts the run at that clock edge, with no further instructions issued.

Program store writes:
- mem[prog_addr] <= prog_data on a clock edge with prog_we=1, only in IDLE or DONE.
- Writes are ignored in CLEAR and RUN.

State machine:
- IDLE:
  - opcode=NOP_OP, cpu_reset=0 (cpu_reset=1 only in the first cycle after reset).
  - start=1 -> CLEAR.
- CLEAR (exactly 1 cycle):
  - opcode=CLR_OP, cpu_reset=1. Next edge: pc<=0, instr_count<=0, timeout<=0 -> RUN.
- RUN:
  - An instruction issues this cycle when step_mode=0, or when step_mode=1 and step=1.
  - On issue: opcode=mem[pc] (combinational from the current pc); at the edge instr_count increments (saturating).
  - No issue: opcode=NOP_OP; pc and instr_count hold.
  - Next pc on issue, decoded from I=mem[pc]:
    - I[7:4]=9: pc<=I[3:0] (unconditional jump).
    - I[7:4]=8: pc<=I[3:0] if zf_in=0, else pc+1.
    - I[7:4]=F: go to DONE, pc holds. The opcode is still presented to the core this cycle.
    - Otherwise: pc<=pc+1, wrapping 15 -> 0 with no flag.
  - zf_in is the ZF sampled in the issue cycle. It reflects the opcode presented in the previous cycle, which may be a NOP, CLR_OP or program instruction. Branches therefore take zero bubble cycles.
  - Exit conditions:
    - If the edge's increment makes instr_count equal MAX_INSTR and I is not halt: DONE, with timeout<=1.
    - halt_in=1 sampled in RUN: DONE at that edge. No issue takes effect that cycle; pc and instr_count hold.
  - Priority within one cycle: reset > halt_in > halt opcode > MAX_INSTR > normal advance.
  - start is ignored in RUN.
- DONE:
  - opcode=NOP_OP, done=1. pc, instr_count and timeout hold for inspection.
  - start=1 -> CLEAR (restart). Program writes are allowed.

Other rules:
- busy = (state==CLEAR || state==RUN); done = (state==DONE).
- All outputs are registered except opcode, which is a combinational mux of state, step qualifier and mem[pc].
- Latency: start edge -> CLEAR opcode next cycle -> first program opcode the following cycle.

Test Plan:
1. Load mem[0..3] = 01,03,05,F0, then pulse start -> opcode sequence E0,01,03,05,F0,50. Ends with done=1, instr_count=4, pc=3, timeout=0.
2. mem[0]=90 (jump to 0), MAX_INSTR=200 -> exactly 200 issues of 90. Ends with done=1, timeout=1, instr_count=200.
3. mem[0]=A0, mem[1]=85, mem[2]=F0, mem[5]=F0, with zf_in forced 0 then 1 on separate runs -> zf=0: pc path 0,1,5 then done; zf=1: pc path 0,1,2 then done.
4. step_mode=1, mem as in test 1, with step pulses every 3rd cycle -> NOP_OP between steps. Issued opcodes 01,03,05,F0 appear only in step cycles; instr_count=4.
5. Assert reset during RUN at pc=2 -> next cycle state IDLE, opcode=50, busy=0, cpu_reset=1. mem contents unchanged, verified by restarting and getting an identical sequence.
6. prog_we during RUN to addr 1 with data FF -> write ignored. After DONE, the same write succeeds and a rerun issues FF at pc=1.
